gpio_32_output_ctrl: RTL and testbench

// - Output-side companion of the GPIO input debounce path: owns the 32-bit output data and

---
 rtl/gpio_32_output_ctrl.sv | 167 ++++++++++++++++
 tb/tb_gpio_32_output_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_32_output_ctrl.sv
// gpio_32_output_ctrl
// Owns the 32-bit GPIO output data and output-enable registers that feed the pad ring.
// Decoded register commands from the APB slave are applied bitwise under a mask, and any
// bit can be given a timed hardware one-shot. The one-shot inverts the bit for a set
// number of PCLK cycles, puts the saved value back and strobes pulse_done for that bit.
// Every output comes straight from a flop, so a command sampled at an edge is visible
// right after that same edge.

module gpio_32_output_ctrl (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_mask,
    input  logic [31:0] cmd_data,
    input  logic [15:0] pulse_cfg,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_oe,
    output logic [31:0] pulse_active,
    output logic [31:0] pulse_done
);

    // Command opcodes as the APB decoder presents them; 6 and 7 are reserved and do nothing.
    typedef enum logic [2:0] {
        OP_WRITE    = 3'd0,
        OP_SET      = 3'd1,
        OP_CLR      = 3'd2,
        OP_TOGGLE   = 3'd3,
        OP_PULSE    = 3'd4,
        OP_OE_WRITE = 3'd5,
        OP_RSVD6    = 3'd6,
        OP_RSVD7    = 3'd7
    } op_e;

    op_e op;
    assign op = op_e'(cmd_op);

    // Architectural state.
    logic [31:0] out_q,    out_d;
    logic [31:0] oe_q,     oe_d;
    logic [31:0] active_q, active_d;
    logic [31:0] done_q,   done_d;
    logic [31:0] save_q,   save_d;
    logic [15:0] cnt_q [32];
    logic [15:0] cnt_d [32];

    // Decoded command views, one per kind of command.
    logic [31:0] level_mask;
    logic [31:0] level_value;
    logic [31:0] pulse_mask;
    logic [31:0] oe_mask;

    // Sort the command into the bits it touches.
    // A level op (WRITE/SET/CLR/TOGGLE) gives every touched bit a new value and cancels
    // any pulse running on it. A PULSE with a zero length is treated as if no command
    // arrived, so pulses that are already running keep counting down.
    always_comb begin
        level_mask  = '0;
        level_value = out_q;
        pulse_mask  = '0;
        oe_mask     = '0;
        if (cmd_valid) begin
            case (op)
                OP_WRITE: begin
                    level_mask  = cmd_mask;
                    level_value = cmd_data;
                end
                OP_SET: begin
                    level_mask  = cmd_mask;
                    level_value = '1;
                end
                OP_CLR: begin
                    level_mask  = cmd_mask;
                    level_value = '0;
                end
                OP_TOGGLE: begin
                    level_mask  = cmd_mask;
                    level_value = ~out_q;
                end
                OP_PULSE: begin
                    if (pulse_cfg != 16'd0) begin
                        pulse_mask = cmd_mask;
                    end
                end
                OP_OE_WRITE: begin
                    oe_mask = cmd_mask;
                end
                default: begin
                    level_mask = '0;
                end
            endcase
        end
    end

    // The output-enable register only changes on OE_WRITE, and only in the masked bits.
    // Pulses never look at it.
    always_comb begin
        oe_d = (oe_q & ~oe_mask) | (cmd_data & oe_mask);
    end

    // Per-bit next-state logic for the output value and its one-shot.
    // A command on a bit beats that bit's own expiry in the same cycle.
    // Retriggering an active bit only reloads its counter. The bit stays inverted and the
    // original value stays saved, so the pulse is simply stretched.
    // A bit expires when its counter would go from 1 to 0. At that point the saved value
    // is restored and a single-cycle done strobe is raised.
    always_comb begin
        out_d    = out_q;
        save_d   = save_q;
        active_d = active_q;
        done_d   = '0;
        cnt_d    = cnt_q;
        for (int i = 0; i < 32; i++) begin
            if (level_mask[i]) begin
                out_d[i]    = level_value[i];
                active_d[i] = 1'b0;
                cnt_d[i]    = '0;
            end else if (pulse_mask[i]) begin
                cnt_d[i] = pulse_cfg;
                if (!active_q[i]) begin
                    save_d[i]   = out_q[i];
                    out_d[i]    = ~out_q[i];
                    active_d[i] = 1'b1;
                end
            end else if (active_q[i]) begin
                if (cnt_q[i] == 16'd1) begin
                    out_d[i]    = save_q[i];
                    active_d[i] = 1'b0;
                    done_d[i]   = 1'b1;
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - 16'd1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    // A reset in the middle of a pulse just drops it, without a done strobe.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            out_q    <= '0;
            oe_q     <= '0;
            active_q <= '0;
            done_q   <= '0;
            save_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            active_q <= active_d;
            done_q   <= done_d;
            save_q   <= save_d;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_out     = out_q;
    assign gpio_oe      = oe_q;
    assign pulse_active = active_q;
    assign pulse_done   = done_q;

endmodule

// File: tb/tb_gpio_32_output_ctrl.sv
// tb_gpio_32_output_ctrl
// Drives directed and randomized commands into gpio_32_output_ctrl. For each cycle, a
// behavioural model predicts the outputs after the next edge and queues the prediction.
// A monitor pops one prediction per clock edge and compares it against the pins.

module tb_gpio_32_output_ctrl;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_mask;
    logic [31:0] cmd_data;
    logic [15:0] pulse_cfg;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic [31:0] pulse_active;
    logic [31:0] pulse_done;

    gpio_32_output_ctrl dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_mask     (cmd_mask),
        .cmd_data     (cmd_data),
        .pulse_cfg    (pulse_cfg),
        .gpio_out     (gpio_out),
        .gpio_oe      (gpio_oe),
        .pulse_active (pulse_active),
        .pulse_done   (pulse_done)
    );

    // Free-running 100 MHz clock.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int          cyc;
        logic [31:0] out;
        logic [31:0] oe;
        logic [31:0] act;
        logic [31:0] done;
    } exp_t;

    exp_t exp_q[$];

    int tests;
    int fails;
    int cycle_no;

    // Model state, kept at the level of the rules rather than the RTL structure.
    // remain[i] is how many more cycles bit i stays inverted, and 0 means no pulse.
    logic [31:0] m_out;
    logic [31:0] m_oe;
    logic [31:0] m_save;
    logic [31:0] m_done;
    int          remain [32];

    // Predict the state after one clock edge with these inputs applied.
    task automatic modelStep(input logic rst_n, input logic valid, input logic [2:0] op,
                             input logic [31:0] mask, input logic [31:0] data,
                             input logic [15:0] cfg);
        logic [31:0] lvl;
        logic [31:0] next_out;
        if (!rst_n) begin
            m_out  = '0;
            m_oe   = '0;
            m_save = '0;
            m_done = '0;
            for (int i = 0; i < 32; i++) remain[i] = 0;
            return;
        end
        m_done   = '0;
        next_out = m_out;
        lvl      = '0;
        if (valid) begin
            case (op)
                3'd0: begin next_out = (m_out & ~mask) | (data & mask); lvl = mask; end
                3'd1: begin next_out = m_out | mask;  lvl = mask; end
                3'd2: begin next_out = m_out & ~mask; lvl = mask; end
                3'd3: begin next_out = m_out ^ mask;  lvl = mask; end
                3'd5: m_oe = (m_oe & ~mask) | (data & mask);
                default: ;
            endcase
        end
        for (int i = 0; i < 32; i++) begin
            if (lvl[i]) begin
                remain[i] = 0;
            end else if (valid && op == 3'd4 && cfg != 16'd0 && mask[i]) begin
                if (remain[i] == 0) begin
                    m_save[i]   = m_out[i];
                    next_out[i] = ~m_out[i];
                end
                remain[i] = int'(cfg);
            end else if (remain[i] > 0) begin
                remain[i] = remain[i] - 1;
                if (remain[i] == 0) begin
                    next_out[i] = m_save[i];
                    m_done[i]   = 1'b1;
                end
            end
        end
        m_out = next_out;
    endtask

    function automatic logic [31:0] modelActive();
        logic [31:0] a;
        a = '0;
        for (int i = 0; i < 32; i++) a[i] = (remain[i] > 0);
        return a;
    endfunction

    // Drive one cycle's inputs at the falling edge and queue what the next rising edge should give.
    task automatic applyStimulus(input logic rst_n, input logic valid, input logic [2:0] op,
                                 input logic [31:0] mask, input logic [31:0] data,
                                 input logic [15:0] cfg);
        exp_t e;
        @(negedge PCLK);
        PRESETn   = rst_n;
        cmd_valid = valid;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_data  = data;
        pulse_cfg = cfg;
        modelStep(rst_n, valid, op, mask, data, cfg);
        cycle_no++;
        e.cyc  = cycle_no;
        e.out  = m_out;
        e.oe   = m_oe;
        e.act  = modelActive();
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 16'd0);
    endtask

    task automatic compareOne(input string name, input int cyc, input logic [31:0] got,
                              input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareOne("gpio_out", e.cyc, gpio_out, e.out);
        compareOne("gpio_oe", e.cyc, gpio_oe, e.oe);
        compareOne("pulse_active", e.cyc, pulse_active, e.act);
        compareOne("pulse_done", e.cyc, pulse_done, e.done);
    endtask

    // Monitor: one prediction is consumed per rising edge, shortly after the edge.
    always @(posedge PCLK) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
        end
    end

    // Watchdog in case the run never reaches its end.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus sequence: directed cases first, then randomized traffic.
    initial begin
        logic [2:0]  rop;
        logic [31:0] rmask;
        logic [15:0] rcfg;
        tests     = 0;
        fails     = 0;
        cycle_no  = 0;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_mask  = '0;
        cmd_data  = '0;
        pulse_cfg = '0;

        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 16'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 16'd0);

        applyStimulus(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 16'd0);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0, 16'd0);
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h0000_0003, 32'h0, 16'd0);
        applyStimulus(1'b1, 1'b1, 3'd2, 32'h0000_0001, 32'h0, 16'd0);
        applyStimulus(1'b1, 1'b1, 3'd3, 32'h8000_0000, 32'h0, 16'd0);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0, 16'd0);

        applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_0010, 32'h0, 16'd5);
        idle(7);

        applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_0001, 32'h0, 16'd4);
        idle(1);
        applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_0001, 32'h0, 16'd4);
        idle(8);

        applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_0001, 32'h0, 16'd4);
        idle(1);
        applyStimulus(1'b1, 1'b1, 3'd2, 32'h0000_0001, 32'h0, 16'd4);
        idle(5);

        applyStimulus(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0);
        applyStimulus(1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd3);
        applyStimulus(1'b1, 1'b1, 3'd5, 32'h0000_00FF, 32'h0000_0F0F, 16'd0);

        applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_00F0, 32'h0, 16'd6);
        idle(2);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 16'd0);
        idle(8);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyStimulus(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom, 16'($urandom));
            end else if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b1, 1'b0, 3'($urandom), $urandom, $urandom, 16'($urandom));
            end else begin
                rop = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom);
                if ($urandom_range(0, 19) == 0) rmask = 32'hFFFF_FFFF;
                else rmask = $urandom & $urandom & $urandom;
                if ($urandom_range(0, 9) == 0) rcfg = 16'd0;
                else if ($urandom_range(0, 29) == 0) rcfg = 16'($urandom_range(20, 60));
                else rcfg = 16'($urandom_range(1, 8));
                applyStimulus(1'b1, 1'b1, rop, rmask, $urandom, rcfg);
            end
        end
        idle(70);

        @(posedge PCLK);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
